// File: rtl/wr_resp_pkg.sv
// Shared AXI B-channel types, response codes and width helper for the write-response demux.
package wr_resp_pkg;

  typedef logic [1:0] bresp_t;

  localparam bresp_t BrespOkay   = 2'b00;
  localparam bresp_t BrespExOkay = 2'b01;
  localparam bresp_t BrespSlvErr = 2'b10;
  localparam bresp_t BrespDecErr = 2'b11;

  // Select-field width for n masters; n >= 2 always yields at least 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/axi_b_skid.sv
// Two-entry skid buffer: output register plus one skid register, upstream ready comes straight
// from a flop so the downstream ready never reaches the upstream ready combinationally.
module axi_b_skid #(
  parameter int unsigned DataW = 8
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [DataW-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [DataW-1:0] o_data
);

  logic             r_out_vld;
  logic [DataW-1:0] r_out_dat;
  logic             r_skid_vld;
  logic [DataW-1:0] r_skid_dat;
  logic             r_rdy;

  logic w_push;
  logic w_pop;
  logic w_out_free;
  logic w_out_load;
  logic w_skid_load;
  logic w_out_vld_d;
  logic w_skid_vld_d;

  assign w_push     = i_valid & r_rdy;
  assign w_pop      = r_out_vld & i_ready;
  assign w_out_free = ~r_out_vld | w_pop;

  // r_rdy tracks !r_skid_vld, so a push never coincides with a full skid register.
  always_comb begin
    w_out_load   = 1'b0;
    w_skid_load  = 1'b0;
    w_out_vld_d  = r_out_vld;
    w_skid_vld_d = r_skid_vld;
    if (w_out_free) begin
      if (r_skid_vld) begin
        w_out_load   = 1'b1;
        w_out_vld_d  = 1'b1;
        w_skid_vld_d = 1'b0;
      end else if (w_push) begin
        w_out_load  = 1'b1;
        w_out_vld_d = 1'b1;
      end else begin
        w_out_vld_d = 1'b0;
      end
    end else if (w_push) begin
      w_skid_load  = 1'b1;
      w_skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_rdy      <= 1'b0;
    end else begin
      r_out_vld  <= w_out_vld_d;
      r_skid_vld <= w_skid_vld_d;
      r_rdy      <= ~w_skid_vld_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_out_load) begin
      r_out_dat <= r_skid_vld ? r_skid_dat : i_data;
    end
    if (w_skid_load) begin
      r_skid_dat <= i_data;
    end
  end

  assign o_ready = r_rdy;
  assign o_valid = r_out_vld;
  assign o_data  = r_out_dat;

endmodule

// File: rtl/wr_resp_demux_1ton.sv
// AXI B-channel 1-to-NUM_M demux routed by a select field in BID, with a registered skid stage
// and a saturating counter for responses whose select addresses no master.
module wr_resp_demux_1ton
  import wr_resp_pkg::*;
#(
  parameter int unsigned NUM_M   = 4,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned SEL_LSB = 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ID_W-1:0]       bid_s,
  input  logic [1:0]            bresp_s,
  input  logic                  bvalid_s,
  output logic                  bready_s,
  output logic [NUM_M*ID_W-1:0] bid_m,
  output logic [NUM_M*2-1:0]    bresp_m,
  output logic [NUM_M-1:0]      bvalid_m,
  input  logic [NUM_M-1:0]      bready_m,
  output logic [7:0]            drop_cnt,
  output logic                  err_sticky,
  input  logic                  err_clr
);

  localparam int unsigned SelW = clog2(NUM_M);

  typedef struct packed {
    logic [SelW-1:0] sel;
    logic [ID_W-1:0] id;
    bresp_t          resp;
  } beat_t;

  logic [SelW-1:0] w_sel;
  logic            w_sel_ok;
  logic            w_drop;
  logic            w_out_vld;
  logic            w_drain;
  logic [NUM_M-1:0] w_hit;
  beat_t           w_in;
  beat_t           w_out;

  logic [7:0] r_drop_cnt;
  logic       r_err;

  assign w_sel    = bid_s[SEL_LSB +: SelW];
  // Only reachable as invalid when NUM_M is not a power of two.
  assign w_sel_ok = ({1'b0, w_sel} < (SelW + 1)'(NUM_M));
  assign w_drop   = bvalid_s & bready_s & ~w_sel_ok;
  assign w_in     = '{sel: w_sel, id: bid_s, resp: bresp_s};

  axi_b_skid #(
    .DataW ($bits(beat_t))
  ) u_skid (
    .aclk    (aclk),
    .areset  (areset),
    .i_valid (bvalid_s & w_sel_ok),
    .o_ready (bready_s),
    .i_data  (w_in),
    .o_valid (w_out_vld),
    .i_ready (w_drain),
    .o_data  (w_out)
  );

  always_comb begin
    w_hit   = '0;
    bid_m   = '0;
    bresp_m = '0;
    w_drain = 1'b0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      w_hit[k]               = w_out_vld & (w_out.sel == SelW'(k));
      bid_m[k*ID_W +: ID_W]  = w_out.id;
      bresp_m[k*2 +: 2]      = w_out.resp;
      w_drain                = w_drain | (w_hit[k] & bready_m[k]);
    end
  end

  assign bvalid_m = w_hit;

  // A discard in the same cycle as err_clr wins over the clear.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_drop_cnt <= 8'd0;
      r_err      <= 1'b0;
    end else if (w_drop) begin
      r_err <= 1'b1;
      if (err_clr) begin
        r_drop_cnt <= 8'd1;
      end else if (r_drop_cnt != 8'hff) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (err_clr) begin
      r_drop_cnt <= 8'd0;
      r_err      <= 1'b0;
    end
  end

  assign drop_cnt   = r_drop_cnt;
  assign err_sticky = r_err;

endmodule
